// File: rtl/tx_rx_pkg.sv
// Definitions shared by the serial transmitter and receiver: frame geometry
// and the receiver FSM state encoding.
package tx_rx_pkg;

    localparam int WORD_W     = 4;
    localparam int N_WORDS    = 4;
    localparam int FRAME_BITS = WORD_W * N_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/rx_bit_counter.sv
// Modulo-MOD counter with synchronous clear, count enable and a terminal-count
// flag that is high while the count sits at MOD-1 (used to cascade counters).
module rx_bit_counter #(
    parameter int MOD = 4,
    parameter int CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc  = (cnt_q == CW'(MOD - 1));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_deserializer.sv
// Serial-to-parallel frame receiver: rebuilds N_WORDS words (word 0 first,
// MSB first), pulses frame_done and flags truncated frames.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per frame.
module rx_deserializer
    import tx_rx_pkg::*;
#(
    parameter int WORD_W  = tx_rx_pkg::WORD_W,
    parameter int N_WORDS = tx_rx_pkg::N_WORDS,
    parameter int BCW     = (WORD_W > 1) ? $clog2(WORD_W) : 1,
    parameter int WCW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic                        rx_data,
    input  logic                        rx_en,
    output logic [N_WORDS*WORD_W-1:0]   words,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        frame_err,
    output logic [1:0]                  state_dbg,
    output logic [BCW-1:0]              bit_cnt_dbg,
    output logic [WCW-1:0]              word_cnt_dbg
);

    localparam int FB = WORD_W * N_WORDS;

    rx_state_e       state_q, state_d;
    logic [FB-1:0]   sr_q, sr_d;
    logic [FB-1:0]   words_q, words_d;
    logic            err_q, err_d;
    logic [FB-1:0]   sr_next;
    logic [FB-1:0]   frame_src;
    logic [FB-1:0]   assembled;
    logic            take;
    logic            cnt_clr;
    logic            bit_tc, word_tc;
    logic            last_bit;
`ifdef PARITY_CHECK_EN
    logic            par_q, par_d;

    // The parity bit is not shifted in and does not advance the counters.
    assign take = rx_en && ((state_q == IDLE) || ((state_q == RECV) && !par_q));
    assign frame_src = sr_q;
`else
    assign take = rx_en && ((state_q == IDLE) || (state_q == RECV));
    assign frame_src = sr_next;
`endif

    assign sr_next  = {sr_q[FB-2:0], rx_data};
    assign cnt_clr  = (state_q == RECV) && !rx_en;
    assign last_bit = take && bit_tc && word_tc;

    rx_bit_counter #(.MOD(WORD_W), .CW(BCW)) u_bit_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .clr   (cnt_clr),
        .en    (take),
        .cnt   (bit_cnt_dbg),
        .tc    (bit_tc)
    );

    rx_bit_counter #(.MOD(N_WORDS), .CW(WCW)) u_word_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .clr   (cnt_clr),
        .en    (take && bit_tc),
        .cnt   (word_cnt_dbg),
        .tc    (word_tc)
    );

    // The first received word lands at the top of the shift register but
    // belongs in the lowest slot of the output bus.
    always_comb begin
        assembled = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            assembled[k*WORD_W +: WORD_W] = frame_src[(N_WORDS-1-k)*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        words_d = words_q;
        err_d   = err_q;
`ifdef PARITY_CHECK_EN
        par_d   = par_q;
`endif
        if (take) begin
            sr_d = sr_next;
        end
        case (state_q)
            IDLE: begin
                if (rx_en) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (!rx_en) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
`ifdef PARITY_CHECK_EN
                    par_d   = 1'b0;
`endif
                end else begin
`ifdef PARITY_CHECK_EN
                    if (par_q) begin
                        par_d = 1'b0;
                        if (^{sr_q, rx_data}) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            words_d = assembled;
                            state_d = DONE;
                        end
                    end else if (last_bit) begin
                        par_d = 1'b1;
                    end
`else
                    if (last_bit) begin
                        words_d = assembled;
                        state_d = DONE;
                    end
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            words_q <= words_d;
            err_q   <= err_d;
`ifdef PARITY_CHECK_EN
            par_q   <= par_d;
`endif
        end
    end

    assign words      = words_q;
    assign frame_done = (state_q == DONE);
    assign busy       = (state_q == RECV);
    assign frame_err  = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer: a frame-level bit-queue model checked
// every cycle, plus literal expectations for each scenario.
module tb_rx_deserializer;
    import tx_rx_pkg::*;

    localparam int W   = WORD_W;
    localparam int N   = N_WORDS;
    localparam int FB  = FRAME_BITS;
    localparam int BCW = (W > 1) ? $clog2(W) : 1;
    localparam int WCW = (N > 1) ? $clog2(N) : 1;
`ifdef PARITY_CHECK_EN
    localparam int LEN = FB + 1;
`else
    localparam int LEN = FB;
`endif

    logic            clk = 1'b0;
    logic            clr_n;
    logic            rx_data;
    logic            rx_en;
    logic [FB-1:0]   words;
    logic            frame_done;
    logic            busy;
    logic            frame_err;
    logic [1:0]      state_dbg;
    logic [BCW-1:0]  bit_cnt_dbg;
    logic [WCW-1:0]  word_cnt_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    rx_deserializer #(.WORD_W(W), .N_WORDS(N)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .words        (words),
        .frame_done   (frame_done),
        .busy         (busy),
        .frame_err    (frame_err),
        .state_dbg    (state_dbg),
        .bit_cnt_dbg  (bit_cnt_dbg),
        .word_cnt_dbg (word_cnt_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [FB-1:0] m_words = '0;
    logic          m_done  = 1'b0;
    logic          m_busy  = 1'b0;
    logic          m_err   = 1'b0;
    bit            bits_q[$];

    always @(posedge clk) begin
        if (!clr_n) begin
            m_words = '0;
            m_done  = 1'b0;
            m_busy  = 1'b0;
            m_err   = 1'b0;
            bits_q.delete();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (rx_en) begin
            bits_q.push_back(rx_data);
            m_busy = 1'b1;
            if (bits_q.size() == LEN) begin
                bit par_ok;
                par_ok = 1'b1;
`ifdef PARITY_CHECK_EN
                begin
                    bit p;
                    p = 1'b0;
                    foreach (bits_q[i]) p ^= bits_q[i];
                    par_ok = (p == 1'b0);
                end
`endif
                m_busy = 1'b0;
                if (par_ok) begin
                    for (int k = 0; k < N; k++)
                        for (int b = 0; b < W; b++)
                            m_words[k*W + (W-1-b)] = bits_q[k*W + b];
                    m_done = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                bits_q.delete();
            end
        end else if (bits_q.size() != 0) begin
            m_err  = 1'b1;
            m_busy = 1'b0;
            bits_q.delete();
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            int nb;
            nb = bits_q.size();
            check("words",      32'(words),        32'(m_words));
            check("frame_done", 32'(frame_done),   32'(m_done));
            check("busy",       32'(busy),         32'(m_busy));
            check("frame_err",  32'(frame_err),    32'(m_err));
            check("bit_cnt",    32'(bit_cnt_dbg),  32'(nb % W));
            check("word_cnt",   32'(word_cnt_dbg), 32'((nb / W) % N));
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bits(input logic [FB-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_en   = 1'b1;
            rx_data = w[(i / W) * W + (W - 1 - (i % W))];
        end
    endtask

    task automatic send_parity(input logic [FB-1:0] w, input bit flip);
        @(negedge clk);
        rx_en   = 1'b1;
        rx_data = (^w) ^ flip;
    endtask

    task automatic send_frame(input logic [FB-1:0] w);
        send_bits(w, FB);
`ifdef PARITY_CHECK_EN
        send_parity(w, 1'b0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_en   = 1'b0;
            rx_data = 1'($urandom_range(0, 1));
        end
    endtask

    // Called on the first idle cycle after a frame: the DONE cycle.
    task automatic expect_frame(input string name, input logic [FB-1:0] w);
        idle(1);
        check({name, "_done"},  32'(frame_done), 32'd1);
        check({name, "_words"}, 32'(words),      32'(w));
        check({name, "_busy"},  32'(busy),       32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        clr_n   = 1'b0;
        rx_en   = 1'b0;
        rx_data = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_words", 32'(words),        32'd0);
        check("rst_done",  32'(frame_done),   32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_err",   32'(frame_err),    32'd0);
        check("rst_state", 32'(state_dbg),    32'd0);
        clr_n = 1'b1;

        // Nominal frame 0xA,0x5,0xF,0x3
        idle(2);
        send_frame(16'h3F5A);
        expect_frame("nominal", 16'h3F5A);
        check("nominal_err", 32'(frame_err), 32'd0);
        idle(1);
        check("nominal_pulse_len", 32'(frame_done), 32'd0);
        check("nominal_hold", 32'(words), 32'h3F5A);

        // Reset after 7 bits of a frame
        send_bits(16'hFFFF, 7);
        @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        clr_n = 1'b0;
        rx_en = 1'b0;
        @(negedge clk);
        check("midrst_busy",     32'(busy),         32'd0);
        check("midrst_bit_cnt",  32'(bit_cnt_dbg),  32'd0);
        check("midrst_word_cnt", 32'(word_cnt_dbg), 32'd0);
        check("midrst_words",    32'(words),        32'd0);
        clr_n = 1'b1;
        idle(1);
        send_frame(16'h1234);
        expect_frame("after_rst", 16'h1234);

        // Truncation after 9 bits
        idle(2);
        d0 = done_cnt;
        send_bits(16'h0F0F, 9);
        idle(1);
        check("trunc_busy_mid", 32'(busy),      32'd1);
        check("trunc_err_mid",  32'(frame_err), 32'd0);
        idle(1);
        check("trunc_err",   32'(frame_err), 32'd1);
        check("trunc_busy",  32'(busy),      32'd0);
        check("trunc_words", 32'(words),     32'h1234);
        idle(3);
        check("trunc_no_done", 32'(done_cnt - d0), 32'd0);

        // Back-to-back frames with a single idle cycle between them
        d0 = done_cnt;
        send_frame(16'h1234);
        expect_frame("b2b_first", 16'h1234);
        send_frame(16'hBEEF);
        expect_frame("b2b_second", 16'hBEEF);
        idle(2);
        check("b2b_pulses", 32'(done_cnt - d0), 32'd2);
        check("b2b_err_sticky", 32'(frame_err), 32'd1);

        // All ones then all zeros
        send_frame(16'hFFFF);
        expect_frame("ones", 16'hFFFF);
        idle(1);
        send_frame(16'h0000);
        expect_frame("zeros", 16'h0000);
        idle(1);
        check("wrap_word_cnt", 32'(word_cnt_dbg), 32'd0);

`ifdef PARITY_CHECK_EN
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        idle(1);
        send_frame(16'hC3A5);
        expect_frame("par_good", 16'hC3A5);
        check("par_good_err", 32'(frame_err), 32'd0);
        idle(1);
        d0 = done_cnt;
        send_bits(16'h5555, FB);
        send_parity(16'h5555, 1'b1);
        idle(2);
        check("par_bad_err",   32'(frame_err), 32'd1);
        check("par_bad_words", 32'(words),     32'hC3A5);
        check("par_bad_done",  32'(done_cnt - d0), 32'd0);
`endif

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
